// File: rtl/fetch_stage.sv
// fetch_stage: PC/next-PC selection, req/ack instruction fetch and IF/ID register
// with stall hold buffer and branch redirect that drains an in-flight request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_STEP   = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [15:0] stall_count
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;
  state_t      state, state_n;
  logic [31:0] pc, pc_n, addr_n, seq;
  logic [31:0] hold_pc4, hold_instr, hold_pc4_n, hold_instr_n;
  logic [31:0] pc4_n, instr_n;
  logic        valid_n;
  assign seq      = imem_addr + 32'(PC_STEP);
  assign imem_req = (state == FETCH) || (state == DROP);
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    addr_n       = imem_addr;
    hold_pc4_n   = hold_pc4;
    hold_instr_n = hold_instr;
    pc4_n        = if_id_pc4;
    instr_n      = if_id_instr;
    valid_n      = if_id_valid;
    if (state == IDLE) begin
      state_n = FETCH;
      addr_n  = pc;
    end else if (branch_taken) begin
      // An unanswered request must still be drained in DROP before redirecting.
      pc_n    = branch_target;
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
      state_n = (state == HOLD || imem_ack) ? FETCH : DROP;
      addr_n  = (state == HOLD || imem_ack) ? branch_target : imem_addr;
    end else if (state == HOLD) begin
      if (!stall) begin
        pc4_n   = hold_pc4;
        instr_n = hold_instr;
        valid_n = 1'b1;
        addr_n  = pc;
        state_n = FETCH;
      end
    end else if (state == DROP) begin
      if (!stall) begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
      end
      if (imem_ack) begin
        addr_n  = pc;
        state_n = FETCH;
      end
    end else if (imem_ack && !stall) begin
      pc4_n   = seq;
      instr_n = imem_rdata;
      valid_n = 1'b1;
      pc_n    = seq;
      addr_n  = seq;
    end else if (imem_ack) begin
      hold_pc4_n   = seq;
      hold_instr_n = imem_rdata;
      pc_n         = seq;
      state_n      = HOLD;
    end else if (!stall) begin
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      hold_pc4    <= '0;
      hold_instr  <= NOP_INSTR;
      if_id_pc4   <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      imem_addr   <= addr_n;
      hold_pc4    <= hold_pc4_n;
      hold_instr  <= hold_instr_n;
      if_id_pc4   <= pc4_n;
      if_id_instr <= instr_n;
      if_id_valid <= valid_n;
      stall_count <= (stall && stall_count != 16'hFFFF) ? stall_count + 16'd1 : stall_count;
    end
  end
endmodule
